// File: rtl/add_subt_pipe_if.sv
// Operand/result bundle for the carry-pipelined add/subtract unit.
// The master drives the operation; the slave (the adder) returns the result.
interface add_subt_pipe_if #(
    parameter int unsigned W = 26
);
    logic         Stall_i;
    logic         Valid_i;
    logic         Add_Subt_i;
    logic [W-1:0] Op_A_i;
    logic [W-1:0] Op_B_i;
    logic         Valid_o;
    logic [W-1:0] Sum_o;
    logic         C_o;
    logic         Zero_o;
    logic [W-1:0] P_o;

    modport master (
        output Stall_i, Valid_i, Add_Subt_i, Op_A_i, Op_B_i,
        input  Valid_o, Sum_o, C_o, Zero_o, P_o
    );

    modport slave (
        input  Stall_i, Valid_i, Add_Subt_i, Op_A_i, Op_B_i,
        output Valid_o, Sum_o, C_o, Zero_o, P_o
    );
endinterface

// File: rtl/add_subt_pipe.sv
// Carry-pipelined W-bit unsigned add/subtract (mantissa adder). Segment k of
// the operands is resolved in stage k+1; its carry is registered forward.
module add_subt_pipe #(
    parameter int unsigned W      = 26,
    parameter int unsigned STAGES = 2
) (
    input  logic          clk,
    input  logic          rst,
    add_subt_pipe_if.slave bus
);
    localparam int unsigned SW   = W / STAGES;
    localparam int unsigned LAST = STAGES - 1;

    // Per stage: operands (B already conditionally inverted), partial sum,
    // carry out of the segment resolved in that stage, and valid.
    logic [STAGES-1:0][W-1:0] r_a;
    logic [STAGES-1:0][W-1:0] r_b;
    logic [STAGES-1:0][W-1:0] r_sum;
    logic [STAGES-1:0]        r_c;
    logic [STAGES-1:0]        r_v;
    logic                     r_zero;

    logic [STAGES-1:0][W-1:0] w_a_in;
    logic [STAGES-1:0][W-1:0] w_b_in;
    logic [STAGES-1:0][W-1:0] w_sum_in;
    logic [STAGES-1:0]        w_c_in;
    logic [STAGES-1:0]        w_v_in;
    logic [STAGES-1:0][W-1:0] w_sum_nxt;
    logic [STAGES-1:0]        w_c_nxt;
    logic [STAGES-1:0][SW:0]  w_cc;
    logic                     w_zero;

    always_comb begin
        w_a_in    = '0;
        w_b_in    = '0;
        w_sum_in  = '0;
        w_c_in    = '0;
        w_v_in    = '0;
        w_sum_nxt = '0;
        w_c_nxt   = '0;
        w_cc      = '0;

        // Stage 1 takes the live operands; subtract is A + ~B + 1.
        w_a_in[0] = bus.Op_A_i;
        w_b_in[0] = bus.Op_B_i ^ {W{bus.Add_Subt_i}};
        w_c_in[0] = bus.Add_Subt_i;
        w_v_in[0] = bus.Valid_i;
        for (int unsigned s = 1; s < STAGES; s++) begin
            w_a_in[s]   = r_a[s-1];
            w_b_in[s]   = r_b[s-1];
            w_sum_in[s] = r_sum[s-1];
            w_c_in[s]   = r_c[s-1];
            w_v_in[s]   = r_v[s-1];
        end

        // Ripple segment s; bits already resolved upstream pass through.
        for (int unsigned s = 0; s < STAGES; s++) begin
            w_sum_nxt[s] = w_sum_in[s];
            w_cc[s][0]   = w_c_in[s];
            for (int unsigned i = 0; i < SW; i++) begin
                w_sum_nxt[s][s*SW+i] = w_a_in[s][s*SW+i] ^ w_b_in[s][s*SW+i] ^ w_cc[s][i];
                w_cc[s][i+1] = (w_a_in[s][s*SW+i] & w_b_in[s][s*SW+i])
                             | ((w_a_in[s][s*SW+i] ^ w_b_in[s][s*SW+i]) & w_cc[s][i]);
            end
            w_c_nxt[s] = w_cc[s][SW];
        end
    end

    assign w_zero = (w_sum_nxt[LAST] == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_sum  <= '0;
            r_c    <= '0;
            r_v    <= '0;
            r_zero <= 1'b0;
        end else if (!bus.Stall_i) begin
            r_a    <= w_a_in;
            r_b    <= w_b_in;
            r_sum  <= w_sum_nxt;
            r_c    <= w_c_nxt;
            r_v    <= w_v_in;
            r_zero <= w_zero;
        end
    end

    assign bus.Valid_o = r_v[LAST];
    assign bus.Sum_o   = r_sum[LAST];
    assign bus.C_o     = r_c[LAST];
    assign bus.Zero_o  = r_zero;
    assign bus.P_o     = r_a[LAST] ^ r_b[LAST];
endmodule
